// File: rtl/tx_sched_if.sv
// Bundle between tx_sched, its byte requesters and the UART transmitter pins.
// The requester/transmitter side drives the master modport; the scheduler is the slave.
interface tx_sched_if #(
  parameter int NREQ = 4
);
  // Handshake: a requester holds req[i] with its byte stable on req_data until gnt[i]
  // pulses for one cycle (byte taken) or it withdraws. tx_start is a one-cycle launch
  // into the transmitter and tx_ready (tbr) is high whenever the transmitter is idle.
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_en;
  logic [NREQ-1:0]   gnt;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_ready;
  logic              busy;
  logic              err_tmo;
  logic [15:0]       bytes_sent;
  logic [1:0]        state_dbg;

  modport master (
    output req, req_data, req_en, tx_ready,
    input  gnt, tx_data, tx_start, busy, err_tmo, bytes_sent, state_dbg
  );

  modport slave (
    input  req, req_data, req_en, tx_ready,
    output gnt, tx_data, tx_start, busy, err_tmo, bytes_sent, state_dbg
  );
endinterface

// File: rtl/tx_sched.sv
// Round-robin transmit scheduler: shares one UART transmitter among NREQ byte requesters,
// launches each byte with a one-cycle start pulse and tracks tbr until the frame completes.
module tx_sched #(
  parameter int NREQ     = 4,
  parameter int BUSY_TMO = 4
) (
  input  logic      clk,
  input  logic      rst,
  tx_sched_if.slave bus
);
  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(BUSY_TMO + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  logic [LW-1:0]   r_last;
  logic [CW-1:0]   r_cnt;
  logic [NREQ-1:0] r_gnt;
  logic [7:0]      r_tx_data;
  logic            r_tx_start;
  logic            r_err_tmo;
  logic [15:0]     r_bytes_sent;

  logic [NREQ-1:0] w_masked;
  logic [LW-1:0]   w_win;
  logic            w_found;
  logic [7:0]      w_bytes [NREQ];

  assign w_masked = bus.req & bus.req_en;

  for (genvar g = 0; g < NREQ; g++) begin : g_bytes
    assign w_bytes[g] = bus.req_data[8*g+7:8*g];
  end

  // Search upward starting just after the last winner, wrapping at NREQ.
  always_comb begin : p_rr
    int idx;
    idx     = 0;
    w_win   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(r_last) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_found && w_masked[LW'(idx)]) begin
        w_found = 1'b1;
        w_win   = LW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_last       <= LW'(NREQ - 1);
      r_cnt        <= '0;
      r_gnt        <= '0;
      r_tx_data    <= 8'h00;
      r_tx_start   <= 1'b0;
      r_err_tmo    <= 1'b0;
      r_bytes_sent <= 16'h0000;
    end else begin
      r_tx_start <= 1'b0;
      r_gnt      <= '0;
      r_err_tmo  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.tx_ready && w_found) begin
            r_tx_data  <= w_bytes[w_win];
            r_tx_start <= 1'b1;
            r_gnt      <= {{(NREQ-1){1'b0}}, 1'b1} << w_win;
            r_last     <= w_win;
            r_state    <= S_START;
          end
        end
        S_START: begin
          r_cnt   <= '0;
          r_state <= S_BUSY;
        end
        S_BUSY: begin
          if (!bus.tx_ready) begin
            r_state <= S_DONE;
          end else if (r_cnt == CW'(BUSY_TMO - 1)) begin
            // Transmitter never accepted the start; drop the frame uncounted.
            r_err_tmo <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (bus.tx_ready) begin
            r_bytes_sent <= r_bytes_sent + 16'd1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt        = r_gnt;
  assign bus.tx_data    = r_tx_data;
  assign bus.tx_start   = r_tx_start;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.err_tmo    = r_err_tmo;
  assign bus.bytes_sent = r_bytes_sent;
  assign bus.state_dbg  = r_state;
endmodule

// File: tb/tb_tx_sched.sv
// Directed bench for tx_sched: expected {gnt, byte} pairs are queued when requests are
// driven and popped when the scheduler launches a frame; tx_ready is driven as the transmitter.
module tb_tx_sched;
  localparam int NREQ = 4;
  localparam int W    = NREQ + 8;

  logic clk;
  logic rst;
  tx_sched_if #(.NREQ(NREQ)) bus ();

  tx_sched #(.NREQ(NREQ), .BUSY_TMO(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] exp_q[$];
  logic [7:0]   tb_byte [NREQ];
  logic [15:0]  exp_bytes;
  int           n_vec;
  int           n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_data();
    for (int i = 0; i < NREQ; i++) bus.req_data[8*i +: 8] = tb_byte[i];
  endtask

  task automatic push_exp(input int idx);
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    exp_q.push_back({oh, tb_byte[idx]});
  endtask

  // Waits (bounded) for the start pulse, then checks it against the scoreboard head.
  task automatic wait_start(output logic [W-1:0] e, output bit ok);
    ok = 1'b0;
    e  = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.tx_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("start_seen", {31'd0, ok}, 32'd1);
    if (!ok) return;
    if (exp_q.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    chk("gnt", {28'd0, bus.gnt}, {28'd0, e[W-1:8]});
    chk("tx_data", {24'd0, bus.tx_data}, {24'd0, e[7:0]});
    chk("busy_start", {31'd0, bus.busy}, 32'd1);
  endtask

  task automatic run_frame(input int frame_len, input bit clear_req);
    logic [W-1:0] e;
    bit ok;
    wait_start(e, ok);
    if (!ok) return;
    if (clear_req) bus.req = '0;
    bus.tx_ready = 1'b0;
    @(negedge clk);
    chk("start_one_cycle", {31'd0, bus.tx_start}, 32'd0);
    chk("gnt_one_cycle", {28'd0, bus.gnt}, 32'd0);
    for (int c = 0; c < frame_len; c++) begin
      @(negedge clk);
      chk("data_hold", {24'd0, bus.tx_data}, {24'd0, e[7:0]});
      chk("busy_frame", {31'd0, bus.busy}, 32'd1);
    end
    bus.tx_ready = 1'b1;
    @(negedge clk);
    exp_bytes = exp_bytes + 16'd1;
    chk("busy_end", {31'd0, bus.busy}, 32'd0);
    chk("bytes_sent", {16'd0, bus.bytes_sent}, {16'd0, exp_bytes});
  endtask

  initial begin
    logic [W-1:0] e;
    bit ok;
    n_vec = 0;
    n_fail = 0;
    exp_bytes = 16'h0000;

    // reset with arbitrary requests applied
    rst = 1'b0;
    bus.req = 4'b1111;
    bus.req_en = 4'b1111;
    bus.tx_ready = 1'b1;
    bus.req_data = $urandom;
    repeat (3) @(negedge clk);
    chk("rst_gnt", {28'd0, bus.gnt}, 32'd0);
    chk("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    chk("rst_tx_start", {31'd0, bus.tx_start}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_err", {31'd0, bus.err_tmo}, 32'd0);
    chk("rst_bytes", {16'd0, bus.bytes_sent}, 32'd0);
    chk("rst_state", {30'd0, bus.state_dbg}, 32'd0);

    // round robin: first grant after reset is requester 0
    tb_byte[0] = 8'h11; tb_byte[1] = 8'h22; tb_byte[2] = 8'h33; tb_byte[3] = 8'h44;
    load_data();
    for (int i = 0; i < 8; i++) push_exp(i % NREQ);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) run_frame($urandom_range(1, 4), i == 7);
    chk("rr_bytes", {16'd0, bus.bytes_sent}, 32'd8);

    // single byte from requester 2
    tb_byte[2] = 8'hA5;
    load_data();
    bus.req = 4'b0100;
    push_exp(2);
    run_frame(3, 1'b1);

    // mask: only 1 and 3 eligible, alternating (last winner was 2)
    bus.req_en = 4'b1010;
    bus.req = 4'b1111;
    push_exp(3); push_exp(1); push_exp(3); push_exp(1);
    for (int i = 0; i < 4; i++) run_frame($urandom_range(1, 3), i == 3);
    bus.req_en = 4'b1111;

    // timeout: transmitter never drops ready
    tb_byte[0] = 8'h5A;
    load_data();
    bus.req = 4'b0001;
    push_exp(0);
    wait_start(e, ok);
    bus.req = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("tmo_err_low", {31'd0, bus.err_tmo}, 32'd0);
      chk("tmo_busy", {31'd0, bus.busy}, 32'd1);
    end
    @(negedge clk);
    chk("tmo_err_pulse", {31'd0, bus.err_tmo}, 32'd1);
    chk("tmo_idle", {30'd0, bus.state_dbg}, 32'd0);
    chk("tmo_bytes", {16'd0, bus.bytes_sent}, {16'd0, exp_bytes});
    @(negedge clk);
    chk("tmo_err_once", {31'd0, bus.err_tmo}, 32'd0);

    // wrap: preload the frame counter near its limit
    force dut.r_bytes_sent = 16'hFFFE;
    @(negedge clk);
    release dut.r_bytes_sent;
    exp_bytes = 16'hFFFE;
    bus.req = 4'b0010;
    push_exp(1);
    run_frame(2, 1'b1);
    chk("wrap_ffff", {16'd0, bus.bytes_sent}, 32'h0000FFFF);
    bus.req = 4'b0100;
    push_exp(2);
    run_frame(2, 1'b1);
    chk("wrap_zero", {16'd0, bus.bytes_sent}, 32'd0);

    // reset while the frame is in DONE
    bus.req = 4'b1000;
    push_exp(3);
    wait_start(e, ok);
    bus.req = '0;
    bus.tx_ready = 1'b0;
    @(negedge clk);
    chk("mid_state_busy", {30'd0, bus.state_dbg}, 32'd2);
    @(negedge clk);
    chk("mid_state_done", {30'd0, bus.state_dbg}, 32'd3);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_bytes", {16'd0, bus.bytes_sent}, 32'd0);
    chk("mid_rst_data", {24'd0, bus.tx_data}, 32'd0);
    chk("mid_rst_state", {30'd0, bus.state_dbg}, 32'd0);
    exp_bytes = 16'h0000;
    bus.tx_ready = 1'b1;
    bus.req = 4'b1111;
    push_exp(0);
    rst = 1'b1;
    run_frame(1, 1'b1);

    chk("sb_drained", exp_q.size(), 32'd0);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/tx_sched.md
# tx_sched

Transmit scheduler for the mini SPART serial path. It shares the single UART transmitter among `NREQ` byte requesters using round-robin arbitration. It sequences each byte into the transmitter with a one-cycle start pulse and tracks the transmitter's ready flag until the frame completes. It sits between the requesting logic (bus interface, debug/status sources) and the transmitter's `data`/`en_tx`/`tbr` pins.

## Interface
- `NREQ`, default 4: number of requesters (2..8).
- `BUSY_TMO`, default 4: maximum cycles from start pulse to transmitter ready falling before a fault is declared.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `req`  in  NREQ  per-requester byte request, level; held until granted or withdrawn.
- `req_data`  in  8*NREQ  packed bytes; requester i uses bits [8*i+7:8*i].
- `req_en`  in  NREQ  configuration mask; a requester with a 0 bit is never granted.
- `gnt`  out  NREQ  one-hot, one-cycle acknowledge that requester's byte was taken.
- `tx_data`  out  8  byte to transmitter `data`.
- `tx_start`  out  1  one-cycle start pulse to transmitter `en_tx`.
- `tx_ready`  in  1  transmitter `tbr`: high when transmitter idle.
- `busy`  out  1  high while a frame is in flight.
- `err_tmo`  out  1  one-cycle pulse: transmitter failed to go busy after start.
- `bytes_sent`  out  16  count of completed frames, wraps 0xFFFF->0x0000.

## Operation
- States: IDLE, START, BUSY, DONE.
- IDLE: if `tx_ready`=1 and (`req` & `req_en`) != 0, select a winner and go to START. Otherwise stay.
- Winner selection is round-robin: search upward from index `last`+1 modulo NREQ. The first set masked request wins.
- `last` resets to NREQ-1, so requester 0 has highest priority after reset.
- On the IDLE->START transition, the following are registered:
  - `tx_data` <= winner's byte
  - `tx_start` <= 1
  - `gnt` <= one-hot(winner)
  - `last` <= winner
- START (one cycle): `tx_start` and `gnt` are high this cycle only. Next state is BUSY.
- BUSY: wait for `tx_ready`=0, then go to DONE.
  - A counter counts BUSY cycles.
  - If `tx_ready` is still 1 after BUSY_TMO cycles, pulse `err_tmo`, return to IDLE, and do not increment `bytes_sent`.
- DONE: wait for `tx_ready`=1, then increment `bytes_sent` and go to IDLE. No timeout applies; frame length is set by the baud enable.
- `busy` = 1 in START, BUSY and DONE.
- `tx_data` holds its value from START until the next grant; it is never changed mid-frame.
- `tx_start` is never high for more than one consecutive cycle, because the transmitter treats a held `en_tx` as a retrigger.
- Requests arriving or changing during START/BUSY/DONE are ignored until IDLE.
- `req_en` is sampled only in IDLE.
- A request withdrawn before grant is simply not served.
- After `gnt`, the requester may immediately reassert with a new byte. It competes normally at the next IDLE.

## Timing
- Reset (`rst`=0 at a rising edge) sets `gnt`=0, `tx_data`=0x00, `tx_start`=0, `busy`=0, `err_tmo`=0, `bytes_sent`=0, state IDLE, `last`=NREQ-1.
- Reset mid-frame aborts scheduling immediately. The in-flight frame is not counted.
- Grant latency: request seen in IDLE at edge N; `gnt`/`tx_start` high during cycle N+1.
- Transmitter ready falls at N+2 in normal operation, so BUSY lasts 1 cycle.
- Frame completion: the first edge in DONE with `tx_ready`=1 increments `bytes_sent` and enters IDLE.
- Minimum gap between successive `tx_start` pulses: frame time + 2 cycles.
- Timeout: `err_tmo` pulses in the cycle after the BUSY_TMO-th BUSY cycle with `tx_ready` still 1.
- Simultaneous events: `tx_ready` rising in DONE while a request is pending yields DONE->IDLE, then START one cycle later. There is no bypass from DONE.

## Test plan
- Reset value check: hold `rst`=0 with arbitrary `req`. Release. All outputs are 0; the first grant with `req`=4'b1111 goes to requester 0.
- Single byte: `req`=4'b0100, `req_data`[23:16]=0xA5, transmitter model ready. Expect `gnt`=4'b0100 and `tx_start`=1 for exactly one cycle, `tx_data`=0xA5, `busy` high until ready returns, `bytes_sent`=1.
- Round-robin fairness: all four requests held continuously for 8 frames. Grant order is 0,1,2,3,0,1,2,3; `bytes_sent`=8.
- Mask: `req`=4'b1111, `req_en`=4'b1010. Only 1 and 3 are granted, alternating; 0 and 2 are never granted.
- Timeout: the transmitter model keeps `tx_ready`=1 after start. `err_tmo` pulses once, 4 BUSY cycles after START. State returns to IDLE and `bytes_sent` is unchanged.
- Wrap and mid-frame reset:
  - Preload traffic to `bytes_sent`=0xFFFF; one more frame gives 0x0000.
  - Then assert `rst` during DONE: `busy`=0 next cycle, no count.
